// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and control bundle for the shift-add multiplier datapath
package mult_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 5;
  localparam int PW_DEF = 2 * N_DEF;

  // Field order mirrors the controller's output concatenation.
  typedef struct packed {
    logic clr;
    logic shftb;
    logic shftp;
    logic loadab;
    logic loadp;
  } ctrl_t;

  function automatic logic [2:0] strobe_count(input ctrl_t c);
    strobe_count = 3'(c.clr) + 3'(c.shftb) + 3'(c.shftp) + 3'(c.loadab) + 3'(c.loadp);
  endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// rtl/mult_datapath_if.sv - control strobes, operands and product bus; ctrl_err exists only with MULT_CTRL_CHK_EN
interface mult_datapath_if #(
  parameter int N  = 4,
  parameter int CW = 5
);
  logic            clr;
  logic            loadab;
  logic            loadp;
  logic            shftp;
  logic            shftb;
  logic [N-1:0]    a_in;
  logic [N-1:0]    b_in;
  logic [2*N-1:0]  p_out;
  logic            p_valid;
  logic [CW-1:0]   iter;
`ifdef MULT_CTRL_CHK_EN
  logic            ctrl_err;
`endif

  modport master (
    output clr, loadab, loadp, shftp, shftb, a_in, b_in,
`ifdef MULT_CTRL_CHK_EN
    input  ctrl_err,
`endif
    input  p_out, p_valid, iter
  );

  modport slave (
    input  clr, loadab, loadp, shftp, shftb, a_in, b_in,
`ifdef MULT_CTRL_CHK_EN
    output ctrl_err,
`endif
    output p_out, p_valid, iter
  );

endinterface

// File: rtl/mult_addn.sv
// rtl/mult_addn.sv - N-bit unsigned adder with (N+1)-bit sum for the loadp accumulate
module mult_addn #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - A/B/P/C registers of the shift-add multiplier; MULT_CTRL_CHK_EN adds sticky ctrl_err
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mult_datapath_if.slave  bus
);

  localparam int PW = 2 * N;
  localparam logic [CW-1:0] ITER_DONE = CW'(N);
  localparam logic [CW-1:0] ITER_MAX  = '1;

  ctrl_t ctrl;
  assign ctrl = {bus.clr, bus.shftb, bus.shftp, bus.loadab, bus.loadp};

  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [PW-1:0] p_q, p_d;
  logic          c_q, c_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  addend;
  logic [N:0]    acc_sum;
  logic [CW-1:0] iter_inc;

  assign addend   = b_q[0] ? a_q : '0;
  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;

  mult_addn #(.N(N)) u_addn (
    .a   (p_q[PW-1:N]),
    .b   (addend),
    .sum (acc_sum)
  );

  // Priority chain guarantees a single action per cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    c_d     = c_q;
    iter_d  = iter_q;
    valid_d = valid_q;
    if (ctrl.clr) begin
      a_d     = '0;
      b_d     = '0;
      p_d     = '0;
      c_d     = 1'b0;
      iter_d  = '0;
      valid_d = 1'b0;
    end else if (ctrl.loadab) begin
      a_d     = bus.a_in;
      b_d     = bus.b_in;
      iter_d  = '0;
      valid_d = 1'b0;
    end else if (ctrl.loadp) begin
      {c_d, p_d[PW-1:N]} = acc_sum;
    end else if (ctrl.shftp) begin
      p_d     = {c_q, p_q[PW-1:1]};
      c_d     = 1'b0;
      iter_d  = iter_inc;
      valid_d = valid_q | (iter_inc == ITER_DONE);
    end else if (ctrl.shftb) begin
      b_d = {1'b0, b_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      iter_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      c_q     <= c_d;
      iter_q  <= iter_d;
      valid_q <= valid_d;
    end
  end

  assign bus.p_out   = p_q;
  assign bus.p_valid = valid_q;
  assign bus.iter    = iter_q;

`ifdef MULT_CTRL_CHK_EN
  logic err_q, err_d;

  // Flags overlapping strobes and any accumulate/shift issued after the run completed.
  always_comb begin
    err_d = err_q;
    if (strobe_count(ctrl) >= 3'd2)
      err_d = 1'b1;
    if ((ctrl.loadp || ctrl.shftp) && (iter_q == ITER_DONE))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign bus.ctrl_err = err_q;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - directed vectors for mult_datapath; checks ctrl_err when MULT_CTRL_CHK_EN is defined
module tb_mult_datapath;

  localparam int N  = 4;
  localparam int CW = 5;

  localparam logic [4:0] S_NONE   = 5'b00000;
  localparam logic [4:0] S_CLR    = 5'b10000;
  localparam logic [4:0] S_SHFTB  = 5'b01000;
  localparam logic [4:0] S_SHFTP  = 5'b00100;
  localparam logic [4:0] S_LOADAB = 5'b00010;
  localparam logic [4:0] S_LOADP  = 5'b00001;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mult_datapath_if #(.N(N), .CW(CW)) bus ();

  mult_datapath #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] s);
    {bus.clr, bus.shftb, bus.shftp, bus.loadab, bus.loadp} = s;
    @(posedge clk);
    #1;
    {bus.clr, bus.shftb, bus.shftp, bus.loadab, bus.loadp} = S_NONE;
  endtask

  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    bus.a_in = a;
    bus.b_in = b;
    step(S_CLR);
    step(S_LOADAB);
    bus.a_in = ~a;
    bus.b_in = ~b;
    for (int i = 0; i < N; i++) begin
      step(S_LOADP);
      if (i == N - 1)
        check({tag, " valid_before_last"}, 32'(bus.p_valid), 32'd0);
      step(S_SHFTP);
      if (i < N - 1)
        step(S_SHFTB);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'd143};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    vecs[3] = '{a: 4'd7,  b: 4'd6,  p: 8'd42};
    vecs[4] = '{a: 4'd1,  b: 4'd15, p: 8'd15};
    vecs[5] = '{a: 4'd15, b: 4'd1,  p: 8'd15};

    bus.a_in = '0;
    bus.b_in = '0;
    {bus.clr, bus.shftb, bus.shftp, bus.loadab, bus.loadp} = S_NONE;

    // reset with random strobes
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {bus.clr, bus.shftb, bus.shftp, bus.loadab, bus.loadp} = 5'($urandom_range(0, 31));
      bus.a_in = 4'($urandom_range(0, 15));
      bus.b_in = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    check("rst p_out", 32'(bus.p_out), 32'd0);
    check("rst p_valid", 32'(bus.p_valid), 32'd0);
    check("rst iter", 32'(bus.iter), 32'd0);
`ifdef MULT_CTRL_CHK_EN
    check("rst ctrl_err", 32'(bus.ctrl_err), 32'd0);
`endif
    {bus.clr, bus.shftb, bus.shftp, bus.loadab, bus.loadp} = S_NONE;
    rst = 1'b1;

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      run_mult(vecs[k].a, vecs[k].b, tag);
      check({tag, " p_out"}, 32'(bus.p_out), 32'(vecs[k].p));
      check({tag, " p_valid"}, 32'(bus.p_valid), 32'd1);
      check({tag, " iter"}, 32'(bus.iter), 32'd4);
      step(S_NONE);
      check({tag, " hold"}, 32'(bus.p_out), 32'(vecs[k].p));
    end
`ifdef MULT_CTRL_CHK_EN
    check("std seq ctrl_err", 32'(bus.ctrl_err), 32'd0);
`endif

    // reset in the middle of a 15x15 run
    bus.a_in = 4'd15;
    bus.b_in = 4'd15;
    step(S_CLR);
    step(S_LOADAB);
    step(S_LOADP);
    step(S_SHFTP);
    step(S_SHFTB);
    step(S_LOADP);
    step(S_SHFTP);
    check("mid p_nonzero", 32'(bus.p_out != 0), 32'd1);
    rst = 1'b0;
    step(S_LOADP);
    rst = 1'b1;
    check("midrst p_out", 32'(bus.p_out), 32'd0);
    check("midrst iter", 32'(bus.iter), 32'd0);
    check("midrst p_valid", 32'(bus.p_valid), 32'd0);
    run_mult(4'd7, 4'd6, "fresh");
    check("fresh p_out", 32'(bus.p_out), 32'd42);

    // loadab and loadp together: only the load happens (P holds 0x2A)
    bus.a_in = 4'd5;
    bus.b_in = 4'd3;
    step(S_LOADAB | S_LOADP);
    check("dual p_out", 32'(bus.p_out), 32'h2A);
    check("dual iter", 32'(bus.iter), 32'd0);
    check("dual p_valid", 32'(bus.p_valid), 32'd0);
    step(S_LOADP);
    check("dual followup", 32'(bus.p_out), 32'h7A);
`ifdef MULT_CTRL_CHK_EN
    check("dual ctrl_err", 32'(bus.ctrl_err), 32'd1);
    step(S_CLR);
    check("sticky ctrl_err", 32'(bus.ctrl_err), 32'd1);
`endif
    rst = 1'b0;
    step(S_NONE);
    rst = 1'b1;
`ifdef MULT_CTRL_CHK_EN
    check("cleared ctrl_err", 32'(bus.ctrl_err), 32'd0);
`endif

    // extra shftp after completion, then saturation
    run_mult(4'd13, 4'd11, "extra");
    check("extra pre p_out", 32'(bus.p_out), 32'd143);
    step(S_SHFTP);
    check("extra p_out", 32'(bus.p_out), 32'd71);
    check("extra p_valid", 32'(bus.p_valid), 32'd1);
    check("extra iter", 32'(bus.iter), 32'd5);
`ifdef MULT_CTRL_CHK_EN
    check("extra ctrl_err", 32'(bus.ctrl_err), 32'd1);
`endif
    for (int i = 0; i < 30; i++)
      step(S_SHFTP);
    check("sat iter", 32'(bus.iter), 32'd31);
    check("sat p_valid", 32'(bus.p_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
